// File: rtl/fport_telemetry_tx.sv
// FPort downlink telemetry transmitter: builds one CRC'd, byte-stuffed 0x81 data frame per
// request and paces it into uart_tx, holding the half-duplex driver enable through a guard time.
module fport_telemetry_tx #(
    parameter int         GUARD_CYCLES = 50,
    parameter logic [7:0] FRAME_TYPE   = 8'h81,
    parameter logic [7:0] PRIM         = 8'h10
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_app_id,
    input  logic [31:0] req_data,
    input  logic        uart_busy,
    output logic        uart_send,
    output logic [7:0]  uart_data,
    output logic        tx_enable,
    output logic        frame_done
);
    localparam logic [7:0] FLAG = 8'h7E;
    localparam logic [7:0] ESC  = 8'h7D;
    localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 1) ? GUARD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_START, WAIT_END, GUARD} state_t;

    state_t        state;
    logic [7:0]    body [10];
    logic [7:0]    payload [9];
    logic [7:0]    crc_byte;
    logic [8:0]    crc_sum;
    logic [7:0]    crc_acc;
    logic [3:0]    idx;
    logic          stuff_pending;
    logic [7:0]    esc_byte;
    logic [CW-1:0] guard_cnt;
    logic          is_body;
    logic          need_stuff;
    logic [3:0]    bsel;
    logic [7:0]    logical_byte;
    logic [7:0]    wire_byte;
    logic          do_emit;

    // Handshake: a request transfers on any cycle with req_valid && req_ready; req_ready is
    // high only in IDLE, so requests outside IDLE are simply not taken (no queueing).
    assign req_ready = (state == IDLE);

    always_comb begin
        payload[0] = 8'h08;
        payload[1] = FRAME_TYPE;
        payload[2] = PRIM;
        payload[3] = req_app_id[7:0];
        payload[4] = req_app_id[15:8];
        payload[5] = req_data[7:0];
        payload[6] = req_data[15:8];
        payload[7] = req_data[23:16];
        payload[8] = req_data[31:24];
    end

    // Running sum with end-around carry folded back in after every byte.
    always_comb begin
        crc_acc = '0;
        crc_sum = '0;
        for (int i = 0; i < 9; i++) begin
            crc_sum = {1'b0, crc_acc} + {1'b0, payload[i]};
            crc_acc = crc_sum[7:0] + {7'd0, crc_sum[8]};
        end
        crc_byte = 8'hFF - crc_acc;
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && req_valid) begin
            for (int i = 0; i < 9; i++) body[i] <= payload[i];
            body[9] <= crc_byte;
        end
    end

    // idx walks the logical frame: 0 = start flag, 1..10 = payload+CRC, 11 = end flag.
    always_comb begin
        is_body      = (idx >= 4'd1) && (idx <= 4'd10);
        bsel         = is_body ? idx - 4'd1 : 4'd0;
        logical_byte = is_body ? body[bsel] : FLAG;
        need_stuff   = is_body && (logical_byte == FLAG || logical_byte == ESC);
        if (stuff_pending)   wire_byte = esc_byte;
        else if (need_stuff) wire_byte = ESC;
        else                 wire_byte = logical_byte;
        do_emit = !uart_busy && ((state == IDLE && req_valid) || state == SEND);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= IDLE;
            uart_send     <= 1'b0;
            uart_data     <= 8'h00;
            tx_enable     <= 1'b0;
            frame_done    <= 1'b0;
            idx           <= 4'd0;
            stuff_pending <= 1'b0;
            esc_byte      <= 8'h00;
            guard_cnt     <= '0;
        end else begin
            uart_send  <= 1'b0;
            frame_done <= 1'b0;
            if (do_emit) begin
                uart_send <= 1'b1;
                uart_data <= wire_byte;
                if (stuff_pending) begin
                    stuff_pending <= 1'b0;
                    idx           <= idx + 4'd1;
                end else if (need_stuff) begin
                    stuff_pending <= 1'b1;
                    esc_byte      <= logical_byte ^ 8'h20;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
            case (state)
                IDLE: begin
                    // An idle UART lets the start flag go out on the accept edge itself.
                    if (req_valid) begin
                        tx_enable <= 1'b1;
                        state     <= uart_busy ? SEND : WAIT_START;
                    end
                end
                SEND: begin
                    if (!uart_busy) state <= WAIT_START;
                end
                WAIT_START: begin
                    if (uart_busy) state <= WAIT_END;
                end
                WAIT_END: begin
                    if (!uart_busy) begin
                        if (stuff_pending || idx <= 4'd11) begin
                            state <= SEND;
                        end else if (GUARD_CYCLES <= 1) begin
                            state      <= IDLE;
                            tx_enable  <= 1'b0;
                            frame_done <= 1'b1;
                            idx        <= 4'd0;
                        end else begin
                            state     <= GUARD;
                            guard_cnt <= CW'(1);
                        end
                    end
                end
                GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        state      <= IDLE;
                        tx_enable  <= 1'b0;
                        frame_done <= 1'b1;
                        idx        <= 4'd0;
                    end else begin
                        guard_cnt <= guard_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fport_telemetry_tx.sv
// Bench for fport_telemetry_tx: a busy-counter UART model, an observer at the falling edge,
// and a reference frame builder computed straight from the FPort framing rules.
module tb_fport_telemetry_tx;
    localparam int GUARD = 50;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_app_id = 16'h0;
    logic [31:0] req_data = 32'h0;
    logic        uart_busy;
    logic        uart_send;
    logic [7:0]  uart_data;
    logic        tx_enable;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    fport_telemetry_tx #(.GUARD_CYCLES(GUARD), .FRAME_TYPE(8'h81), .PRIM(8'h10)) dut (
        .clock(clock), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_app_id(req_app_id), .req_data(req_data),
        .uart_busy(uart_busy), .uart_send(uart_send), .uart_data(uart_data),
        .tx_enable(tx_enable), .frame_done(frame_done)
    );

    // UART model: busy for busy_len cycles starting the cycle after a send pulse.
    int busy_len = 10;
    int busy_cnt = 0;
    always @(posedge clock) begin
        if (uart_send) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_busy = (busy_cnt != 0);

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int send_cyc_q[$];
    int acc_cyc_q[$];
    int proto_err = 0;
    int last_fall_cyc = 0;
    int done_cyc = 0;
    int txen_fall_cyc = 0;
    int txen_falls = 0;
    logic prev_busy = 1'b0;
    logic prev_txen = 1'b0;

    always @(negedge clock) begin
        if (uart_send === 1'b1) begin
            got_q.push_back(uart_data);
            send_cyc_q.push_back(cyc);
            if (uart_busy || !tx_enable) proto_err++;
        end
        if (req_valid && req_ready === 1'b1 && !rst) acc_cyc_q.push_back(cyc);
        if (frame_done === 1'b1) done_cyc = cyc;
        if (prev_busy && !uart_busy) last_fall_cyc = cyc;
        if (prev_txen && tx_enable === 1'b0) begin
            txen_fall_cyc = cyc;
            txen_falls++;
        end
        prev_busy = uart_busy;
        prev_txen = (tx_enable === 1'b1);
    end

    // Reference frame: payload, additive CRC with carry fold, then stuff everything but the flags.
    function automatic void model_append(input logic [15:0] id, input logic [31:0] d);
        int p[10];
        int c;
        p[0] = 8'h08; p[1] = 8'h81; p[2] = 8'h10;
        p[3] = int'(id[7:0]);  p[4] = int'(id[15:8]);
        p[5] = int'(d[7:0]);   p[6] = int'(d[15:8]);
        p[7] = int'(d[23:16]); p[8] = int'(d[31:24]);
        c = 0;
        for (int i = 0; i < 9; i++) begin
            c = c + p[i];
            c = (c + (c >> 8)) & 255;
        end
        p[9] = 255 - c;
        exp_q.push_back(8'h7E);
        for (int i = 0; i < 10; i++) begin
            if (p[i] == 126 || p[i] == 125) begin
                exp_q.push_back(8'h7D);
                exp_q.push_back(8'(p[i] ^ 32));
            end else begin
                exp_q.push_back(8'(p[i]));
            end
        end
        exp_q.push_back(8'h7E);
    endfunction

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0:       return 8'h7E;
            1:       return 8'h7D;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic clear_obs();
        exp_q.delete();
        got_q.delete();
        send_cyc_q.delete();
        acc_cyc_q.delete();
        proto_err = 0;
        txen_falls = 0;
    endtask

    task automatic start_req(input logic [15:0] id, input logic [31:0] d, output bit ok);
        ok = 0;
        @(posedge clock); #1;
        req_app_id = id;
        req_data = d;
        req_valid = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock);
            if (req_ready) begin ok = 1; break; end
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock); #1;
            if (frame_done) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_cmp++; if (uart_send !== 1'b0) begin n_bad++; $display("FAIL reset_uart_send got %b want 0", uart_send); end
        n_cmp++; if (uart_data !== 8'h00) begin n_bad++; $display("FAIL reset_uart_data got %h want 00", uart_data); end
        n_cmp++; if (tx_enable !== 1'b0) begin n_bad++; $display("FAIL reset_tx_enable got %b want 0", tx_enable); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        @(posedge clock); #1;
        rst = 1'b0;
    endtask

    task automatic test_spec_vectors();
        logic [7:0] vec [3][13];
        int vlen [3];
        logic [15:0] ids [3];
        logic [31:0] dats [3];
        bit ok1, ok2;
        vec[0] = '{8'h7E, 8'h08, 8'h81, 8'h10, 8'h10, 8'h02, 8'hD2, 8'h04, 8'h00, 8'h00, 8'h7D, 8'h5D, 8'h7E};
        vec[1] = '{8'h7E, 8'h08, 8'h81, 8'h10, 8'h10, 8'h01, 8'h7D, 8'h5E, 8'h00, 8'h00, 8'h00, 8'hD6, 8'h7E};
        vec[2] = '{8'h7E, 8'h08, 8'h81, 8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h66, 8'h7E, 8'h00};
        vlen[0] = 13; vlen[1] = 13; vlen[2] = 12;
        ids[0] = 16'h0210; dats[0] = 32'h0000_04D2;
        ids[1] = 16'h0110; dats[1] = 32'h0000_007E;
        ids[2] = 16'hFFFF; dats[2] = 32'hFFFF_FFFF;
        busy_len = 10;
        for (int v = 0; v < 3; v++) begin
            clear_obs();
            start_req(ids[v], dats[v], ok1);
            wait_done(ok2);
            n_cmp++; if (!(ok1 && ok2)) begin n_bad++; $display("FAIL vec%0d_timeout got accept=%0d done=%0d want 1/1", v, ok1, ok2); end
            n_cmp++; if (got_q.size() != vlen[v]) begin n_bad++; $display("FAIL vec%0d_len got %0d want %0d", v, got_q.size(), vlen[v]); end
            for (int i = 0; i < vlen[v] && i < got_q.size(); i++) begin
                n_cmp++; if (got_q[i] !== vec[v][i]) begin n_bad++; $display("FAIL vec%0d_byte%0d got %h want %h", v, i, got_q[i], vec[v][i]); end
            end
            n_cmp++; if (proto_err != 0) begin n_bad++; $display("FAIL vec%0d_protocol got %0d bad sends want 0", v, proto_err); end
            n_cmp++; if (txen_falls != 1 || txen_fall_cyc != done_cyc) begin n_bad++; $display("FAIL vec%0d_txen got falls=%0d at %0d want 1 at %0d", v, txen_falls, txen_fall_cyc, done_cyc); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] id1, id2;
        logic [31:0] d1, d2;
        int done1, fall1, n1;
        bit seen;
        id1 = 16'h5A7E; d1 = 32'h1234_7D00;
        id2 = 16'h0400; d2 = $urandom;
        busy_len = 10;
        clear_obs();
        model_append(id1, d1);
        n1 = exp_q.size();
        model_append(id2, d2);
        @(posedge clock); #1;
        req_app_id = id1; req_data = d1; req_valid = 1'b1;
        for (int t = 0; t < 100 && acc_cyc_q.size() < 1; t++) begin @(negedge clock); #1; end
        @(posedge clock); #1;
        req_app_id = id2; req_data = d2;
        seen = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock); #1;
            if (frame_done) begin seen = 1; break; end
        end
        done1 = done_cyc;
        fall1 = last_fall_cyc;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL b2b_first_done got timeout want frame_done"); end
        n_cmp++; if (done1 - fall1 != GUARD) begin n_bad++; $display("FAIL guard_len got %0d want %0d", done1 - fall1, GUARD); end
        n_cmp++; if (txen_fall_cyc != done1) begin n_bad++; $display("FAIL guard_txen_fall got cycle %0d want %0d", txen_fall_cyc, done1); end
        for (int t = 0; t < 10 && acc_cyc_q.size() < 2; t++) begin @(negedge clock); #1; end
        @(posedge clock); #1;
        req_valid = 1'b0;
        wait_done(seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL b2b_second_done got timeout want frame_done"); end
        n_cmp++; if (acc_cyc_q.size() != 2) begin n_bad++; $display("FAIL b2b_accepts got %0d want 2", acc_cyc_q.size()); end
        if (acc_cyc_q.size() == 2) begin
            n_cmp++; if (acc_cyc_q[1] != done1) begin n_bad++; $display("FAIL b2b_accept_cycle got %0d want %0d", acc_cyc_q[1], done1); end
            if (send_cyc_q.size() > n1) begin
                n_cmp++; if (send_cyc_q[n1] != acc_cyc_q[1] + 1) begin n_bad++; $display("FAIL b2b_first_send got cycle %0d want %0d", send_cyc_q[n1], acc_cyc_q[1] + 1); end
            end
        end
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ignore_midframe();
        bit ok1, ok2;
        logic [15:0] id;
        logic [31:0] d;
        id = 16'($urandom); d = $urandom;
        busy_len = 4;
        clear_obs();
        model_append(id, d);
        start_req(id, d, ok1);
        for (int t = 0; t < 500 && got_q.size() < 3; t++) begin @(negedge clock); #1; end
        @(posedge clock); #1;
        req_app_id = ~id; req_data = ~d; req_valid = 1'b1;
        @(negedge clock);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL ignore_ready got %b want 0", req_ready); end
        @(posedge clock); #1;
        req_valid = 1'b0;
        wait_done(ok2);
        n_cmp++; if (!(ok1 && ok2)) begin n_bad++; $display("FAIL ignore_timeout got accept=%0d done=%0d want 1/1", ok1, ok2); end
        n_cmp++; if (acc_cyc_q.size() != 1) begin n_bad++; $display("FAIL ignore_accepts got %0d want 1", acc_cyc_q.size()); end
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ignore_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ignore_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok1, ok2;
        logic [15:0] id;
        logic [31:0] d;
        busy_len = 10;
        clear_obs();
        start_req(16'h7D7E, 32'h7E7D_7E7D, ok1);
        for (int t = 0; t < 500 && got_q.size() < 5; t++) begin @(negedge clock); #1; end
        repeat (4) @(negedge clock);
        @(posedge clock); #1;
        rst = 1'b1;
        @(posedge clock); #1;
        rst = 1'b0;
        @(negedge clock);
        n_cmp++; if (tx_enable !== 1'b0) begin n_bad++; $display("FAIL rstmid_tx_enable got %b want 0", tx_enable); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_req_ready got %b want 1", req_ready); end
        n_cmp++; if (uart_send !== 1'b0) begin n_bad++; $display("FAIL rstmid_uart_send got %b want 0", uart_send); end
        repeat (30) @(negedge clock);
        #1;
        n_cmp++; if (got_q.size() != 5) begin n_bad++; $display("FAIL rstmid_no_more_sends got %0d sends want 5", got_q.size()); end
        id = 16'($urandom); d = $urandom;
        clear_obs();
        model_append(id, d);
        start_req(id, d, ok1);
        wait_done(ok2);
        n_cmp++; if (!(ok1 && ok2)) begin n_bad++; $display("FAIL rstmid_timeout got accept=%0d done=%0d want 1/1", ok1, ok2); end
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rstmid_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rstmid_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_frames();
        bit ok1, ok2;
        logic [15:0] id;
        logic [31:0] d;
        for (int f = 0; f < 10; f++) begin
            id = {rand_byte(), rand_byte()};
            d = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
            busy_len = $urandom_range(1, 6);
            clear_obs();
            model_append(id, d);
            start_req(id, d, ok1);
            wait_done(ok2);
            n_cmp++; if (!(ok1 && ok2)) begin n_bad++; $display("FAIL rand%0d_timeout got accept=%0d done=%0d want 1/1", f, ok1, ok2); end
            n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand%0d_len got %0d want %0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_byte%0d got %h want %h", f, i, got_q[i], exp_q[i]); end
            end
            n_cmp++; if (done_cyc - last_fall_cyc != GUARD) begin n_bad++; $display("FAIL rand%0d_guard got %0d want %0d", f, done_cyc - last_fall_cyc, GUARD); end
            n_cmp++; if (proto_err != 0) begin n_bad++; $display("FAIL rand%0d_protocol got %0d bad sends want 0", f, proto_err); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion by %0t want finish", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fport_telemetry_tx.md
Name: fport_telemetry_tx

Overview:
- Downlink half of the FPort link: builds and serialises one FPort telemetry response frame (0x81 data frame) per request, with FPort byte stuffing and CRC.
- Drives the existing uart_tx byte transmitter through its send/busy interface on the shared RC pin.
- Asserts a direction enable so top can turn the half-duplex line around.
- Sits beside the FPort uplink decoder in top and is fed by the sensor/telemetry scheduler.

Parameters:
GUARD_CYCLES, 50, clocks tx_enable stays high after the last byte completes (line turnaround guard); 0 allowed
FRAME_TYPE, 8'h81, FPort downlink frame type byte
PRIM, 8'h10, SPort primitive byte (data frame)

Ports:
clock  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
req_valid  in  1  request to send one telemetry frame
req_ready  out  1  high only in IDLE; request accepted on cycle req_valid&&req_ready
req_app_id  in  16  SPort application ID, sent little-endian
req_data  in  32  sensor value, sent little-endian
uart_busy  in  1  from uart_tx; high while a byte is shifting out
uart_send  out  1  one-cycle pulse to uart_tx, qualifying uart_data
uart_data  out  8  byte to transmit
tx_enable  out  1  half-duplex driver enable
frame_done  out  1  one-cycle pulse when frame and guard are complete

Behaviour:
- Reset values: req_ready=1 (IDLE), uart_send=0, uart_data=0, tx_enable=0, frame_done=0. Reset mid-frame aborts: state returns to IDLE the cycle after rst, and no further uart_send is issued. The partially sent frame is dropped, not resumed.
- On accept, latch app_id/data and form the 9 logical payload bytes: 0x08, FRAME_TYPE, PRIM, id[7:0], id[15:8], d[7:0], d[15:8], d[23:16], d[31:24].
- CRC over these 9 unstuffed bytes: c=(c+b); c=(c+(c>>8))&0xFF, starting from c=0. The CRC byte is 0xFF-c.
- Wire order is 0x7E, the 9 payload bytes, CRC, 0x7E.
- Stuffing applies to payload and CRC only: bytes 0x7E and 0x7D are sent as 0x7D followed by (b^0x20). The start and end flags are never stuffed.
- Frame length on the wire is 12–22 bytes.
- FSM states:
  - IDLE: req_ready=1. On accept, go to SEND and set tx_enable=1 from the next cycle.
  - SEND: when uart_busy=0, pulse uart_send for one cycle with uart_data valid in that same cycle, then go to WAIT_START.
  - WAIT_START: wait for uart_busy=1.
  - WAIT_END: wait for uart_busy=0. Then go to SEND if bytes remain (including the pending second half of a stuffed pair), otherwise go to GUARD.
  - GUARD: count GUARD_CYCLES with tx_enable=1. Then drop tx_enable, pulse frame_done, and go to IDLE. With GUARD_CYCLES=0, frame_done fires on the cycle after the last busy fall.
- Minimum latency: accept at cycle N gives the first uart_send at N+1.
- req_valid outside IDLE is ignored, with no queueing. A request on the cycle after frame_done is accepted.
- uart_data holds its last value between pulses. Only its value during uart_send is significant.
- Exactly one uart_send is issued per wire byte, and never while uart_busy=1.

Test Plan:
1. app_id=0x0210, data=0x000004D2, uart model busy 10 cycles → bytes 7E 08 81 10 10 02 D2 04 00 00 7D 5D 7E. The CRC 0x7D is stuffed. Expect 13 uart_send pulses and tx_enable high throughout.
2. app_id=0x0110, data=0x0000007E → 7E 08 81 10 10 01 7D 5E 00 00 00 D6 7E (payload stuffing).
3. app_id=0xFFFF, data=0xFFFFFFFF → 7E 08 81 10 FF FF FF FF FF FF 66 7E. This checks carry folding; exactly 12 bytes.
4. GUARD_CYCLES=50: tx_enable falls exactly 50 cycles after the final uart_busy fall, with frame_done in the same cycle. A back-to-back req_valid held high is accepted the next cycle, and its first uart_send follows 1 cycle later.
5. req_valid pulsed mid-frame → ignored; req_ready=0; the byte stream is unchanged.
6. rst asserted while the 5th byte is in WAIT_END → next cycle tx_enable=0, req_ready=1, no further uart_send. A new request afterwards produces a complete, correct frame.
